// File: rtl/snn_ctrl_pkg.sv
// Shared types and defaults for the SNN stage sequencing control path.
package snn_ctrl_pkg;

  localparam int unsigned DEF_N_STAGES = 3;
  localparam int unsigned DEF_TS_W     = 16;
  localparam int unsigned DEF_TO_W     = 12;

  // Per-stage mode encoding carried on stage_mode
  localparam logic MODE_CONV = 1'b1;
  localparam logic MODE_POOL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_ADVANCE,
    S_PAUSED,
    S_FINISH,
    S_ERROR
  } seq_state_t;

endpackage

// File: rtl/snn_next_stage_finder.sv
// Priority search over the stage mask: lowest set bit overall and lowest set bit above cur_idx.
module snn_next_stage_finder #(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned IDX_W    = 2
) (
  input  logic [N_STAGES-1:0] mask,
  input  logic [IDX_W-1:0]    cur_idx,
  output logic [IDX_W-1:0]    next_idx,
  output logic                next_valid,
  output logic [IDX_W-1:0]    first_idx
);

  // Scan high to low so the last hit is the lowest qualifying index
  always_comb begin
    next_idx   = '0;
    next_valid = 1'b0;
    first_idx  = '0;
    for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_idx = IDX_W'(i);
        if (i > int'(cur_idx)) begin
          next_idx   = IDX_W'(i);
          next_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snn_stage_sequencer.sv
// Sequences masked processing stages across timesteps with enable/active/ready handshakes,
// pause at stage boundaries, abort with soft clear, and per-phase handshake timeout.
module snn_stage_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned N_STAGES = DEF_N_STAGES,
  parameter int unsigned TS_W     = DEF_TS_W,
  parameter int unsigned TO_W     = DEF_TO_W,
  parameter int unsigned IDX_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  input  logic [TS_W-1:0]     num_timesteps,
  input  logic [N_STAGES-1:0] stage_mask,
  input  logic [N_STAGES-1:0] mode_cfg,
  input  logic [TO_W-1:0]     timeout_cycles,
  input  logic [N_STAGES-1:0] stage_active,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_enable,
  output logic [N_STAGES-1:0] stage_mode,
  output logic                stage_clear,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IDX_W-1:0]    err_stage,
  output logic [IDX_W-1:0]    cur_stage,
  output logic [TS_W-1:0]     cur_timestep
);

  seq_state_t state_q, state_d;

  logic [TS_W-1:0]     num_ts_q, num_ts_d;
  logic [N_STAGES-1:0] mask_q, mask_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [TO_W-1:0]     cnt_q, cnt_d;

  logic [N_STAGES-1:0] stage_enable_d, stage_mode_d;
  logic                stage_clear_d, busy_d, done_d, error_d;
  logic [IDX_W-1:0]    err_stage_d, cur_stage_d;
  logic [TS_W-1:0]     cur_timestep_d;

  logic [N_STAGES-1:0] find_mask;
  logic [IDX_W-1:0]    next_idx, first_idx;
  logic                next_valid;
  logic                to_en, to_expire;

  // In IDLE the first stage comes from the incoming mask; afterwards from the latched one
  assign find_mask = (state_q == S_IDLE) ? stage_mask : mask_q;
  assign to_en     = (to_q != '0);
  assign to_expire = to_en && (cnt_q <= TO_W'(1));

  snn_next_stage_finder #(
    .N_STAGES (N_STAGES),
    .IDX_W    (IDX_W)
  ) u_finder (
    .mask       (find_mask),
    .cur_idx    (cur_stage),
    .next_idx   (next_idx),
    .next_valid (next_valid),
    .first_idx  (first_idx)
  );

  // Next-state, datapath updates and registered-output precompute
  always_comb begin
    state_d        = state_q;
    num_ts_d       = num_ts_q;
    mask_d         = mask_q;
    to_d           = to_q;
    cnt_d          = cnt_q;
    stage_mode_d   = stage_mode;
    cur_stage_d    = cur_stage;
    cur_timestep_d = cur_timestep;
    error_d        = error;
    err_stage_d    = err_stage;
    stage_clear_d  = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      stage_clear_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_ts_d       = num_timesteps;
            mask_d         = stage_mask;
            stage_mode_d   = mode_cfg;
            to_d           = timeout_cycles;
            error_d        = 1'b0;
            err_stage_d    = '0;
            cur_timestep_d = '0;
            cur_stage_d    = first_idx;
            state_d        = ((num_timesteps == '0) || (stage_mask == '0)) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_d   = to_q;
          state_d = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (stage_active[cur_stage]) begin
            cnt_d   = to_q;
            state_d = S_WAIT_DONE;
          end else if (to_expire) begin
            state_d       = S_ERROR;
            error_d       = 1'b1;
            err_stage_d   = cur_stage;
            stage_clear_d = 1'b1;
          end else if (to_en) begin
            cnt_d = cnt_q - TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!stage_active[cur_stage] && stage_ready[cur_stage]) begin
            state_d = S_ADVANCE;
          end else if (to_expire) begin
            state_d       = S_ERROR;
            error_d       = 1'b1;
            err_stage_d   = cur_stage;
            stage_clear_d = 1'b1;
          end else if (to_en) begin
            cnt_d = cnt_q - TO_W'(1);
          end
        end
        S_ADVANCE: begin
          if (next_valid) begin
            cur_stage_d = next_idx;
            state_d     = pause ? S_PAUSED : S_ISSUE;
          end else if (cur_timestep == (num_ts_q - TS_W'(1))) begin
            state_d = S_FINISH;
          end else begin
            cur_timestep_d = cur_timestep + TS_W'(1);
            cur_stage_d    = first_idx;
            state_d        = pause ? S_PAUSED : S_ISSUE;
          end
        end
        S_PAUSED: begin
          if (!pause) state_d = S_ISSUE;
        end
        S_FINISH: state_d = S_IDLE;
        S_ERROR:  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_FINISH);
    stage_enable_d = (state_d == S_ISSUE) ? (N_STAGES'(1) << cur_stage_d) : '0;
  end

  // State, latched configuration and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      num_ts_q     <= '0;
      mask_q       <= '0;
      to_q         <= '0;
      cnt_q        <= '0;
      stage_enable <= '0;
      stage_mode   <= '0;
      stage_clear  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_stage    <= '0;
      cur_stage    <= '0;
      cur_timestep <= '0;
    end else begin
      state_q      <= state_d;
      num_ts_q     <= num_ts_d;
      mask_q       <= mask_d;
      to_q         <= to_d;
      cnt_q        <= cnt_d;
      stage_enable <= stage_enable_d;
      stage_mode   <= stage_mode_d;
      stage_clear  <= stage_clear_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      err_stage    <= err_stage_d;
      cur_stage    <= cur_stage_d;
      cur_timestep <= cur_timestep_d;
    end
  end

endmodule

// File: tb/tb_snn_stage_sequencer.sv
// Directed bench for snn_stage_sequencer with a simple responsive stage model.
module tb_snn_stage_sequencer;

  localparam int unsigned N   = 3;
  localparam int unsigned TSW = 16;
  localparam int unsigned TOW = 12;
  localparam int unsigned IW  = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start, abort, pause;
  logic [TSW-1:0] num_timesteps;
  logic [N-1:0]   stage_mask, mode_cfg;
  logic [TOW-1:0] timeout_cycles;
  logic [N-1:0]   stage_active, stage_ready;
  logic [N-1:0]   stage_enable, stage_mode;
  logic           stage_clear, busy, done, error;
  logic [IW-1:0]  err_stage, cur_stage;
  logic [TSW-1:0] cur_timestep;

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  // Stage model / monitor state
  logic [N-1:0] noresp = '0;
  int           hold [N];
  logic [31:0]  en_enc, ts_enc;
  logic [N-1:0] en_or, mode_and, mode_or;
  int           done_cnt, clr_cnt;

  always #5 clk = ~clk;

  snn_stage_sequencer #(
    .N_STAGES (N),
    .TS_W     (TSW),
    .TO_W     (TOW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .pause          (pause),
    .num_timesteps  (num_timesteps),
    .stage_mask     (stage_mask),
    .mode_cfg       (mode_cfg),
    .timeout_cycles (timeout_cycles),
    .stage_active   (stage_active),
    .stage_ready    (stage_ready),
    .stage_enable   (stage_enable),
    .stage_mode     (stage_mode),
    .stage_clear    (stage_clear),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_stage      (err_stage),
    .cur_stage      (cur_stage),
    .cur_timestep   (cur_timestep)
  );

  // Stages ack one cycle after enable and finish one cycle later; also logs activity
  initial begin
    stage_active = '0;
    stage_ready  = '1;
    for (int i = 0; i < int'(N); i++) hold[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(N); i++) begin
        if (!reset_n || stage_clear) begin
          stage_active[i] = 1'b0; stage_ready[i] = 1'b1; hold[i] = 0;
        end else if (stage_enable[i] && !noresp[i]) begin
          stage_active[i] = 1'b1; stage_ready[i] = 1'b0; hold[i] = 1;
        end else if (stage_active[i]) begin
          if (hold[i] > 0) hold[i]--;
          else begin stage_active[i] = 1'b0; stage_ready[i] = 1'b1; end
        end
      end
      if (stage_enable != '0) begin
        en_or    = en_or | stage_enable;
        mode_and = mode_and & stage_mode;
        mode_or  = mode_or | stage_mode;
        for (int i = 0; i < int'(N); i++)
          if (stage_enable[i]) begin
            en_enc = (en_enc << 4) | 32'(i + 1);
            ts_enc = (ts_enc << 4) | (32'(cur_timestep) + 32'd1);
          end
      end
      if (done) done_cnt++;
      if (stage_clear) clr_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Called at a negedge; returns at the negedge after start was sampled with cyc = 1
  task automatic launch(input logic [TSW-1:0] ts, input logic [N-1:0] m, input logic [N-1:0] md,
                        input logic [TOW-1:0] to, input bit with_abort);
    en_enc = '0; ts_enc = '0; en_or = '0; mode_and = '1; mode_or = '0;
    done_cnt = 0; clr_cnt = 0;
    num_timesteps = ts; stage_mask = m; mode_cfg = md; timeout_cycles = to;
    start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int lim);
    while (!done && cyc < lim) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (stage_enable !== 3'b000) begin errs++; $display("FAIL reset_enable: got %b expected 000", stage_enable); end
    vec++; if (stage_mode !== 3'b000) begin errs++; $display("FAIL reset_mode: got %b expected 000", stage_mode); end
    vec++; if ({stage_clear, busy, done, error} !== 4'b0000) begin errs++; $display("FAIL reset_flags: got %b expected 0000", {stage_clear, busy, done, error}); end
    vec++; if ({err_stage, cur_stage, cur_timestep} !== '0) begin errs++; $display("FAIL reset_idx: got %h expected 0", {err_stage, cur_stage, cur_timestep}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    launch(16'd2, 3'b111, 3'b110, 12'd0, 1'b0);
    stage_mask = 3'b001; mode_cfg = 3'b000;   // must not affect latched run
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;       // ignored while busy
    wait_done(100);
    vec++; if (cyc !== 25) begin errs++; $display("FAIL basic_done_cycle: got %0d expected 25", cyc); end
    tick();
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    vec++; if (en_enc !== 32'h123123) begin errs++; $display("FAIL basic_order: got %h expected 123123", en_enc); end
    vec++; if (ts_enc !== 32'h111222) begin errs++; $display("FAIL basic_timestep: got %h expected 111222", ts_enc); end
    vec++; if (done_cnt !== 1) begin errs++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    vec++; if (mode_and !== 3'b110 || mode_or !== 3'b110) begin errs++; $display("FAIL basic_mode: got %b/%b expected 110", mode_and, mode_or); end
    vec++; if (error !== 1'b0) begin errs++; $display("FAIL basic_error: got %b expected 0", error); end
  endtask

  task automatic test_mask_skip();
    launch(16'd2, 3'b101, 3'b011, 12'd0, 1'b0);
    wait_done(100);
    vec++; if (cyc !== 17) begin errs++; $display("FAIL skip_done_cycle: got %0d expected 17", cyc); end
    tick();
    vec++; if (en_enc !== 32'h1313) begin errs++; $display("FAIL skip_order: got %h expected 1313", en_enc); end
    vec++; if (en_or !== 3'b101) begin errs++; $display("FAIL skip_enabled_set: got %b expected 101", en_or); end
    vec++; if (mode_and !== 3'b011 || mode_or !== 3'b011) begin errs++; $display("FAIL skip_mode: got %b/%b expected 011", mode_and, mode_or); end
    vec++; if (ts_enc !== 32'h1122) begin errs++; $display("FAIL skip_timestep: got %h expected 1122", ts_enc); end
  endtask

  task automatic test_timeout();
    noresp = 3'b010;
    launch(16'd1, 3'b111, 3'b000, 12'd5, 1'b0);
    while (!error && cyc < 100) tick();
    vec++; if (cyc !== 11) begin errs++; $display("FAIL to_error_cycle: got %0d expected 11", cyc); end
    vec++; if (err_stage !== 2'd1) begin errs++; $display("FAIL to_err_stage: got %0d expected 1", err_stage); end
    vec++; if (stage_clear !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL to_clear_busy: got %b%b expected 11", stage_clear, busy); end
    tick();
    vec++; if ({stage_clear, busy, error} !== 3'b001) begin errs++; $display("FAIL to_after: got %b expected 001", {stage_clear, busy, error}); end
    tick();
    vec++; if (done_cnt !== 0 || clr_cnt !== 1) begin errs++; $display("FAIL to_pulses: got done %0d clear %0d expected 0 1", done_cnt, clr_cnt); end
    vec++; if (en_enc !== 32'h12) begin errs++; $display("FAIL to_order: got %h expected 12", en_enc); end
    noresp = '0;
  endtask

  task automatic test_pause();
    launch(16'd1, 3'b111, 3'b111, 12'd0, 1'b0);
    vec++; if (error !== 1'b0 || err_stage !== 2'd0) begin errs++; $display("FAIL pause_err_cleared: got %b %0d expected 0 0", error, err_stage); end
    repeat (2) tick();
    pause = 1'b1;                             // stage 0 in WAIT_DONE
    repeat (5) tick();
    vec++; if (cur_stage !== 2'd1 || busy !== 1'b1 || stage_enable !== 3'b000) begin errs++; $display("FAIL pause_hold: got stage %0d busy %b en %b expected 1 1 000", cur_stage, busy, stage_enable); end
    vec++; if (en_enc !== 32'h1) begin errs++; $display("FAIL pause_withheld: got %h expected 1", en_enc); end
    repeat (2) tick();
    pause = 1'b0;
    while (stage_enable == 3'b000 && cyc < 50) tick();
    vec++; if (cyc !== 11 || stage_enable !== 3'b010) begin errs++; $display("FAIL pause_resume: got cycle %0d en %b expected 11 010", cyc, stage_enable); end
    wait_done(100);
    vec++; if (cyc !== 19) begin errs++; $display("FAIL pause_done_cycle: got %0d expected 19", cyc); end
    tick();
    vec++; if (en_enc !== 32'h123) begin errs++; $display("FAIL pause_order: got %h expected 123", en_enc); end
  endtask

  task automatic test_abort();
    launch(16'd1, 3'b111, 3'b000, 12'd0, 1'b0);
    while (cyc < 11) tick();
    abort = 1'b1;                             // stage 2 in WAIT_DONE
    tick();
    abort = 1'b0;
    vec++; if ({stage_clear, busy, done} !== 3'b100) begin errs++; $display("FAIL abort_clear: got %b expected 100", {stage_clear, busy, done}); end
    tick();
    vec++; if (stage_clear !== 1'b0 || done_cnt !== 0 || error !== 1'b0) begin errs++; $display("FAIL abort_after: got clr %b done %0d err %b expected 0 0 0", stage_clear, done_cnt, error); end
    vec++; if (en_enc !== 32'h123) begin errs++; $display("FAIL abort_order: got %h expected 123", en_enc); end
    abort = 1'b1;                             // ignored in IDLE
    repeat (2) tick();
    abort = 1'b0;
    vec++; if (stage_clear !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_idle: got %b%b expected 00", stage_clear, busy); end
    launch(16'd1, 3'b011, 3'b001, 12'd0, 1'b1);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL abort_start_same: got %b expected 1", busy); end
    wait_done(100);
    vec++; if (cyc !== 9) begin errs++; $display("FAIL abort_rerun_cycle: got %0d expected 9", cyc); end
    tick();
    vec++; if (en_enc !== 32'h12 || done_cnt !== 1) begin errs++; $display("FAIL abort_rerun: got %h %0d expected 12 1", en_enc, done_cnt); end
  endtask

  task automatic test_zero();
    launch(16'd0, 3'b111, 3'b101, 12'd0, 1'b0);
    wait_done(20);
    vec++; if (cyc !== 1) begin errs++; $display("FAIL zero_ts_done: got %0d expected 1", cyc); end
    tick();
    vec++; if ({done, busy} !== 2'b00 || en_enc !== 32'h0) begin errs++; $display("FAIL zero_ts_after: got %b %h expected 00 0", {done, busy}, en_enc); end
    vec++; if (stage_mode !== 3'b101) begin errs++; $display("FAIL zero_ts_mode: got %b expected 101", stage_mode); end
    launch(16'd3, 3'b000, 3'b000, 12'd0, 1'b0);
    wait_done(20);
    vec++; if (cyc !== 1) begin errs++; $display("FAIL zero_mask_done: got %0d expected 1", cyc); end
    tick();
    vec++; if (en_enc !== 32'h0 || done_cnt !== 1) begin errs++; $display("FAIL zero_mask_after: got %h %0d expected 0 1", en_enc, done_cnt); end
  endtask

  task automatic test_reset_mid();
    launch(16'd1, 3'b111, 3'b111, 12'd0, 1'b0);
    repeat (5) tick();
    vec++; if (cur_stage !== 2'd1 || busy !== 1'b1) begin errs++; $display("FAIL midrst_pre: got %0d %b expected 1 1", cur_stage, busy); end
    #2 reset_n = 1'b0;
    #1;
    vec++; if ({stage_enable, stage_mode, stage_clear, busy, done, error} !== '0) begin errs++; $display("FAIL midrst_flags: got %h expected 0", {stage_enable, stage_mode, stage_clear, busy, done, error}); end
    vec++; if ({err_stage, cur_stage, cur_timestep} !== '0) begin errs++; $display("FAIL midrst_idx: got %h expected 0", {err_stage, cur_stage, cur_timestep}); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_idle: got %b expected 0", busy); end
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; pause = 1'b0;
    num_timesteps = '0; stage_mask = '0; mode_cfg = '0; timeout_cycles = '0;
    en_enc = '0; ts_enc = '0; en_or = '0; mode_and = '1; mode_or = '0;
    done_cnt = 0; clr_cnt = 0;
    test_reset();
    test_basic();
    test_mask_skip();
    test_timeout();
    test_pause();
    test_abort();
    test_zero();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
